// File: rtl/mux_sel_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mux_sel_arbiter_if
// Brief    : Request/ready inputs and registered mux-select outputs of the
//            round-robin 4:1 mux select arbiter.
// Revision : 1.0
// ============================================================================
interface mux_sel_arbiter_if;
    logic [3:0] req;
    logic       ready;
    logic [1:0] sel;
    logic       valid;
    logic [3:0] grant;
    logic       last;

    // Environment side: requesters plus downstream consumer
    modport master (
        output req,
        output ready,
        input  sel,
        input  valid,
        input  grant,
        input  last
    );

    // Arbiter side
    modport slave (
        input  req,
        input  ready,
        output sel,
        output valid,
        output grant,
        output last
    );
endinterface
`default_nettype wire

// File: rtl/mux_sel_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mux_sel_arbiter
// Brief    : Round-robin arbiter for four channels driving a 4:1 mux select,
//            with bursts of up to HOLD beats per grant and no release bubble.
// Revision : 1.0
// ============================================================================
module mux_sel_arbiter #(
    parameter int HOLD = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    mux_sel_arbiter_if.slave    bus
);

    localparam int             CW       = $clog2(HOLD) + 1;
    localparam logic [CW-1:0]  LAST_CNT = CW'(HOLD - 1);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      sel_q,   sel_d;
    logic [1:0]      ptr_q,   ptr_d;
    logic [CW-1:0]   cnt_q,   cnt_d;
    logic            valid_q, valid_d;
    logic [3:0]      grant_q, grant_d;

    logic            any_req;
    logic            beat;
    logic            release_now;

    // First requester strictly after p, wrapping so p itself is checked last
    function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] win;
        logic [1:0] idx;
        win = p;
        for (int k = 4; k >= 1; k--) begin
            idx = p + 2'(k);
            if (r[idx]) begin
                win = idx;
            end
        end
        return win;
    endfunction

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        any_req     = |bus.req;
        beat        = valid_q & bus.ready;
        release_now = 1'b0;

        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = ACTIVE;
                    sel_d   = pick(bus.req, ptr_q);
                    cnt_d   = '0;
                end
            end
            ACTIVE: begin
                release_now = (beat && (cnt_q == LAST_CNT)) || !bus.req[sel_q];
                if (release_now) begin
                    ptr_d = sel_q;
                    if (any_req) begin
                        // Re-arbitrate on the same edge; the old owner is searched last
                        sel_d = pick(bus.req, sel_q);
                        cnt_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (beat) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        valid_d = (state_d == ACTIVE);
        grant_d = valid_d ? (4'b0001 << sel_d) : 4'b0000;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= 2'b00;
            ptr_q   <= 2'b11;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            grant_q <= 4'b0000;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            grant_q <= grant_d;
        end
    end

    assign bus.sel   = sel_q;
    assign bus.valid = valid_q;
    assign bus.grant = grant_q;
    assign bus.last  = valid_q && (cnt_q == LAST_CNT);

endmodule
`default_nettype wire

// File: tb/tb_mux_sel_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_sel_arbiter
// Brief    : Self-checking bench for mux_sel_arbiter (HOLD=4 and HOLD=1).
// Revision : 1.0
// ============================================================================
module tb_mux_sel_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mux_sel_arbiter_if bus4 ();
    mux_sel_arbiter_if bus1 ();

    mux_sel_arbiter #(.HOLD(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));
    mux_sel_arbiter #(.HOLD(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

    int checks = 0;
    int errors = 0;

    // Reference model: who owns the mux, how many beats used, who was served last
    int hold_of [2] = '{4, 1};
    bit m_act   [2];
    int m_sel   [2];
    int m_beats [2];
    int m_prev  [2];

    typedef struct {
        logic [3:0] req;
        logic       ready;
        logic [1:0] sel;
        logic       valid;
        logic [3:0] grant;
        logic       last;
    } vec_t;

    vec_t tbl [12];

    function automatic vec_t mk(logic [3:0] r, logic rd, logic [1:0] s, logic v,
                                logic [3:0] g, logic l);
        vec_t t;
        t.req = r; t.ready = rd; t.sel = s; t.valid = v; t.grant = g; t.last = l;
        return t;
    endfunction

    function automatic int next_owner(logic [3:0] r, int after);
        for (int k = 1; k <= 4; k++) begin
            if (r[(after + k) % 4]) return (after + k) % 4;
        end
        return after;
    endfunction

    function automatic void m_reset();
        for (int i = 0; i < 2; i++) begin
            m_act[i] = 0; m_sel[i] = 0; m_beats[i] = 0; m_prev[i] = 3;
        end
    endfunction

    function automatic void m_step(logic [3:0] r, logic rdy);
        bit done;
        for (int i = 0; i < 2; i++) begin
            if (!m_act[i]) begin
                if (r != 4'b0000) begin
                    m_act[i] = 1; m_sel[i] = next_owner(r, m_prev[i]); m_beats[i] = 0;
                end
            end else begin
                if (rdy) m_beats[i] = m_beats[i] + 1;
                done = (m_beats[i] >= hold_of[i]) || !r[m_sel[i]];
                if (done) begin
                    m_prev[i] = m_sel[i];
                    if (r != 4'b0000) begin
                        m_sel[i] = next_owner(r, m_prev[i]); m_beats[i] = 0;
                    end else begin
                        m_act[i] = 0;
                    end
                end
            end
        end
    endfunction

    task automatic chk(string nm, logic [3:0] act, logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_model();
        logic [3:0] g;
        for (int i = 0; i < 2; i++) begin
            g = m_act[i] ? (4'b0001 << m_sel[i]) : 4'b0000;
            if (i == 0) begin
                chk("d4.valid", {3'b0, bus4.valid}, {3'b0, m_act[0]});
                if (m_act[0]) chk("d4.sel", {2'b0, bus4.sel}, 4'(m_sel[0]));
                chk("d4.grant", bus4.grant, g);
                chk("d4.last", {3'b0, bus4.last}, {3'b0, m_act[0] && (m_beats[0] == 3)});
            end else begin
                chk("d1.valid", {3'b0, bus1.valid}, {3'b0, m_act[1]});
                if (m_act[1]) chk("d1.sel", {2'b0, bus1.sel}, 4'(m_sel[1]));
                chk("d1.grant", bus1.grant, g);
                chk("d1.last", {3'b0, bus1.last}, {3'b0, m_act[1]});
            end
        end
    endtask

    task automatic drive(logic [3:0] r, logic rdy);
        bus4.req = r; bus4.ready = rdy;
        bus1.req = r; bus1.ready = rdy;
    endtask

    task automatic step(logic [3:0] r, logic rdy);
        drive(r, rdy);
        @(posedge clk);
        m_step(r, rdy);
        #1;
        chk_model();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(4'b0000, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_reset();
    endtask

    logic [3:0] rq;
    logic       rd;

    initial begin
        tbl[0]  = mk(4'b1111, 1, 2'd0, 1, 4'b0001, 0);
        tbl[1]  = mk(4'b1111, 1, 2'd0, 1, 4'b0001, 0);
        tbl[2]  = mk(4'b1111, 1, 2'd0, 1, 4'b0001, 0);
        tbl[3]  = mk(4'b1111, 1, 2'd0, 1, 4'b0001, 1);
        tbl[4]  = mk(4'b1111, 1, 2'd1, 1, 4'b0010, 0);
        tbl[5]  = mk(4'b1111, 1, 2'd1, 1, 4'b0010, 0);
        tbl[6]  = mk(4'b1111, 1, 2'd1, 1, 4'b0010, 0);
        tbl[7]  = mk(4'b1111, 1, 2'd1, 1, 4'b0010, 1);
        tbl[8]  = mk(4'b1111, 1, 2'd2, 1, 4'b0100, 0);
        tbl[9]  = mk(4'b0000, 1, 2'd2, 0, 4'b0000, 0);
        tbl[10] = mk(4'b0000, 1, 2'd2, 0, 4'b0000, 0);
        tbl[11] = mk(4'b1001, 1, 2'd3, 1, 4'b1000, 0);

        drive(4'b0000, 1'b0);
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst.valid", {3'b0, bus4.valid}, 4'h0);
        chk("rst.grant", bus4.grant, 4'h0);
        chk("rst.sel",   {2'b0, bus4.sel}, 4'h0);
        chk("rst.last",  {3'b0, bus4.last}, 4'h0);
        rst_n = 1'b1;

        // Full-request rotation, then idle with held sel, then re-grant
        for (int i = 0; i < 12; i++) begin
            step(tbl[i].req, tbl[i].ready);
            chk($sformatf("tbl%0d.sel", i),   {2'b0, bus4.sel},   {2'b0, tbl[i].sel});
            chk($sformatf("tbl%0d.valid", i), {3'b0, bus4.valid}, {3'b0, tbl[i].valid});
            chk($sformatf("tbl%0d.grant", i), bus4.grant,          tbl[i].grant);
            chk($sformatf("tbl%0d.last", i),  {3'b0, bus4.last},  {3'b0, tbl[i].last});
        end

        // Sole requester stalled by ready=0, then four accepted beats
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(4'b0001, 1'b0);
            chk("stall.valid", {3'b0, bus4.valid}, 4'h1);
            chk("stall.last",  {3'b0, bus4.last},  4'h0);
        end
        step(4'b0001, 1'b1);
        step(4'b0001, 1'b1);
        chk("stall.last2", {3'b0, bus4.last}, 4'h0);
        step(4'b0001, 1'b1);
        chk("stall.last3", {3'b0, bus4.last}, 4'h1);
        step(4'b0001, 1'b1);
        chk("b2b.valid", {3'b0, bus4.valid}, 4'h1);
        chk("b2b.sel",   {2'b0, bus4.sel},   4'h0);

        // Owner drops request mid-burst while stalled
        do_reset();
        step(4'b1100, 1'b1);
        chk("drop.sel0", {2'b0, bus4.sel}, 4'h2);
        step(4'b1100, 1'b1);
        step(4'b1000, 1'b0);
        chk("drop.sel",   {2'b0, bus4.sel}, 4'h3);
        chk("drop.grant", bus4.grant, 4'b1000);
        step(4'b1000, 1'b1);
        step(4'b0000, 1'b1);
        chk("idle.valid", {3'b0, bus4.valid}, 4'h0);
        chk("idle.sel",   {2'b0, bus4.sel},   4'h3);
        step(4'b1001, 1'b1);
        chk("regrant.sel", {2'b0, bus4.sel}, 4'h0);

        // Asynchronous reset mid-burst
        do_reset();
        step(4'b0100, 1'b1);
        step(4'b0100, 1'b1);
        step(4'b0100, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.valid", {3'b0, bus4.valid}, 4'h0);
        chk("arst.grant", bus4.grant, 4'h0);
        chk("arst.sel",   {2'b0, bus4.sel}, 4'h0);
        m_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(4'b0100, 1'b1);
        chk("arst.regrant", {2'b0, bus4.sel}, 4'h2);
        chk("arst.valid1",  {3'b0, bus4.valid}, 4'h1);

        // Randomized traffic with sticky requests so bursts form
        rq = 4'($urandom_range(0, 15));
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 3) == 0) rq = 4'($urandom_range(0, 15));
            rd = ($urandom_range(0, 3) != 0);
            step(rq, rd);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
